// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers, FSM state type and byte indexing
//
// Purpose: constants and pure functions used by the iterative InvMixColumns block.
//   AES_POLY   : low byte of the AES reduction polynomial 0x11B
//   gf_xtime   : multiply a byte by x (0x02) modulo 0x11B
//   gf_mul     : multiply a byte by a 4-bit constant (covers 01..0e)
//   state_e    : IDLE / CALC / DONE
//   byte_idx   : byte position k = 4*row + col inside the 128-bit state
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Shift-and-add over the four constant bits; every MixColumns
  // coefficient in either direction fits in 4 bits.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// rtl/inv_mix_column_word.sv - combinational (Inv)MixColumns on one 32-bit column
//
// Purpose: applies the circulant column matrix to one column.
// Ports:
//   col_i  [31:0] : input column, row r at bits [8r+7:8r]
//   mode_i        : (only with INV_MIX_COLUMNS_FWD_MODE_EN) 1 = forward, 0 = inverse
//   col_o  [31:0] : result column, same layout
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  input  logic        mode_i,
`endif
  output logic [31:0] col_o
);

  logic fwd;
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  assign fwd = mode_i;
`else
  assign fwd = 1'b0;
`endif

  // Coefficient for input row j feeding output row r, indexed by (j - r) mod 4.
  function automatic logic [3:0] coef(input logic [1:0] k, input logic f);
    logic [3:0] c;
    case (k)
      2'd0:    c = f ? 4'h2 : 4'he;
      2'd1:    c = f ? 4'h3 : 4'hb;
      2'd2:    c = f ? 4'h1 : 4'hd;
      default: c = f ? 4'h1 : 4'h9;
    endcase
    return c;
  endfunction

  always_comb begin
    logic [7:0] acc;
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul(col_i[8*j +: 8], coef(2'(j - r), fwd));
      end
      col_o[8*r +: 8] = acc;
    end
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - iterative AES InvMixColumns, one column per cycle
//
// Purpose: accepts a 128-bit AES state, runs one shared column unit over
// columns 0..3 on four successive edges, then presents the result until taken.
// Byte k of in_data/out_data sits at [8k+7:8k]; row = k/4, column = k%4.
// Optional macro INV_MIX_COLUMNS_FWD_MODE_EN adds input mode (1 = forward
// MixColumns, 0 = inverse), latched with the data.
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_ready / in_data[127:0]   : input handshake
//   out_valid / out_ready / out_data[127:0]: output handshake
//   busy                                   : high while computing columns
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] in_q, in_d;
  logic [127:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  col_word, res_word;
  logic         mode_q, mode_d;
  logic         mode_in;

`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
  assign mode_in = mode;
`else
  assign mode_in = 1'b0;
`endif

  // Gather the current column from the latched input.
  always_comb begin
    col_word = '0;
    for (int r = 0; r < 4; r++) begin
      col_word[8*r +: 8] = in_q[8*byte_idx(2'(r), col_q) +: 8];
    end
  end

  inv_mix_column_word u_col (
    .col_i  (col_word),
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
    .mode_i (mode_q),
`endif
    .col_o  (res_word)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    in_d        = in_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_d    = in_data;
          mode_d  = mode_in;
          col_d   = 2'd0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        for (int r = 0; r < 4; r++) begin
          out_d[8*byte_idx(2'(r), col_q) +: 8] = res_word[8*r +: 8];
        end
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        // Ready follows the consumer so a result can leave and a new word
        // can enter on the same edge.
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            in_d    = in_data;
            mode_d  = mode_in;
            col_d   = 2'd0;
            state_d = ST_CALC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      col_q       <= 2'd0;
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      in_q        <= in_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = (state_q == ST_CALC);

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - self-checking bench for inv_mix_columns_iter
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b1;
  logic         mode = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  // Matrix product of the circulant with every column of the state.
  function automatic logic [127:0] mix(input logic [127:0] w, input logic fwd);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (fwd) base = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(w[8*(4*j+c) +: 8], base[(j - r + 4) % 4]);
        res[8*(4*r+c) +: 8] = acc;
      end
    return res;
  endfunction

  // Build a state from four columns; row r of a column is at [8r+7:8r].
  function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  cols [4];
    logic [127:0] w;
    cols = '{c0, c1, c2, c3};
    for (int k = 0; k < 16; k++) w[8*k +: 8] = cols[k % 4][8*(k / 4) +: 8];
    return w;
  endfunction

  // ---------------- cycle-by-cycle scoreboard ----------------
  bit           have_job = 0;
  int           job_acc  = 0;
  logic [127:0] job_res  = '0;

  always @(negedge clk) begin
    bit exp_valid, exp_busy, exp_ir;
    if (!rst) begin
      have_job = 0;
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_busy",      128'(busy),      128'(1'b0));
      chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
      chk("rst_out_data",  out_data,        128'h0);
    end else begin
      exp_valid = have_job && (cyc >= job_acc + 4);
      exp_busy  = have_job && !exp_valid;
      exp_ir    = !have_job || (exp_valid && out_ready);
      chk("sb_out_valid", 128'(out_valid), 128'(exp_valid));
      chk("sb_busy",      128'(busy),      128'(exp_busy));
      chk("sb_in_ready",  128'(in_ready),  128'(exp_ir));
      if (exp_valid) chk("sb_out_data", out_data, job_res);
      if (exp_valid && out_ready) have_job = 0;
      if (in_valid && exp_ir) begin
        have_job = 1;
        job_acc  = cyc + 1;
        job_res  = mix(in_data, mode);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [127:0] w);
    bit got;
    got      = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 128'(got), 128'(1'b1));
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) chk("valid_timeout", 128'(ok), 128'(1'b1));
  endtask

  task automatic run(input string name, input logic [127:0] w, input logic [127:0] exp);
    int acc;
    send(w);
    acc = cyc;
    wait_valid();
    chk({name, "_latency"}, 128'(cyc - acc), 128'(4));
    chk({name, "_data"}, out_data, exp);
    @(posedge clk);
    #1;
  endtask

  logic [127:0] vec_a, exp_a, vec_b, exp_b, vec_c;

  initial begin
    int rel;
    vec_a = mk(32'hbca14d8e, 32'h01010101, 32'h01010101, 32'h01010101);
    exp_a = mk(32'h455313db, 32'h01010101, 32'h01010101, 32'h01010101);
    vec_b = mk(32'hd6d7d5d5, 32'hd6d7d5d5, 32'hd6d7d5d5, 32'hd6d7d5d5);
    exp_b = mk(32'hd5d4d4d4, 32'hd5d4d4d4, 32'hd5d4d4d4, 32'hd5d4d4d4);
    vec_c = mk(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6);

    // Pin the model against hand-computed vectors.
    chk("pin_model_a", mix(vec_a, 1'b0), exp_a);
    chk("pin_model_b", mix(vec_b, 1'b0), exp_b);
    chk("pin_model_c", mix(vec_c, 1'b0), vec_c);
    chk("pin_model_fwd", mix(exp_a, 1'b1), vec_a);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run("vec_a", vec_a, exp_a);
    run("vec_b", vec_b, exp_b);
    run("vec_c", vec_c, vec_c);

    // Back-pressure in DONE, then simultaneous output and input handshakes.
    out_ready = 1'b0;
    send(vec_a);
    wait_valid();
    chk("stall_data0", out_data, exp_a);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data",     out_data,            exp_a);
      chk("stall_in_ready", 128'(in_ready),  128'(1'b0));
      chk("stall_valid",    128'(out_valid), 128'(1'b1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vec_c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("overlap_busy",  128'(busy),      128'(1'b1));
    chk("overlap_valid", 128'(out_valid), 128'(1'b0));
    wait_valid();
    chk("overlap_data", out_data, vec_c);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC when col has reached 2.
    send(vec_b);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid",    128'(out_valid), 128'(1'b0));
    chk("midrst_busy",     128'(busy),      128'(1'b0));
    chk("midrst_in_ready", 128'(in_ready),  128'(1'b1));
    chk("midrst_data",     out_data,        128'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rel = cyc;
    send(vec_a);
    chk("first_accept_edge", 128'(cyc - rel), 128'(1));
    wait_valid();
    chk("postrst_data", out_data, exp_a);
    @(posedge clk);
    #1;

    // Input noise during CALC must not affect the accepted word.
    send(vec_b);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_valid();
    chk("noise_data", out_data, exp_b);
    @(posedge clk);
    #1;

`ifdef INV_MIX_COLUMNS_FWD_MODE_EN
    mode = 1'b1;
    run("fwd", exp_a, vec_a);
    mode = 1'b0;
    run("inv_back", vec_a, exp_a);
`endif

    // Random traffic with random back-pressure, checked by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 The clock port SHALL be clk (input, 1 bit), the single clock; all state SHALL update on its rising edge.
REQ-002 The reset port SHALL be rst (input, 1 bit), asynchronous and active-low.
REQ-003 in_valid SHALL be an input, 1 bit: the in_data word is offered.
REQ-004 in_ready SHALL be an output, 1 bit: the block accepts in_data this cycle.
REQ-005 in_data SHALL be an input, 128 bits: the AES state, with byte k at bits [8k+7:8k], row = k/4 and column = k%4.
REQ-006 out_valid SHALL be an output, 1 bit: out_data holds a result.
REQ-007 out_ready SHALL be an input, 1 bit: the consumer takes out_data.
REQ-008 out_data SHALL be an output, 128 bits: the InvMixColumns result, in the same byte layout as in_data.
REQ-009 busy SHALL be an output, 1 bit: high while in state CALC.

Function
REQ-010 Each result column SHALL be {r0..r3}, with r0=0e·a0^0b·a1^0d·a2^09·a3, r1=09·a0^0e·a1^0b·a2^0d·a3, r2=0d·a0^09·a1^0e·a2^0b·a3 and r3=0b·a0^0d·a1^09·a2^0e·a3; multiplication is in GF(2^8) modulo 0x11B.
REQ-011 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-012 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL latch in_data, clear the column counter col to 0 and go to CALC.
REQ-013 CALC: in_ready=0; each edge SHALL compute column col into the result register and increment col; when col=3 the block SHALL go to DONE and set out_valid=1.
REQ-014 Latency: out_valid SHALL be visible exactly 4 cycles after the acceptance edge.
REQ-015 DONE: out_valid=1 and out_data SHALL be held stable until out_valid&&out_ready.
REQ-016 DONE: in_ready SHALL equal out_ready, so that output and input handshakes can complete on the same edge.
REQ-017 DONE with an output handshake and in_valid=1: the block SHALL latch the new input, go to CALC, and drop out_valid on that edge.
REQ-018 DONE with an output handshake and in_valid=0: the block SHALL go to IDLE and drop out_valid.
REQ-019 in_valid and in_data SHALL be ignored in CALC; no input is lost because in_ready=0 there.
REQ-020 The 2-bit col SHALL never wrap inside CALC; the exit from CALC occurs at col=3.
REQ-021 out_data SHALL retain its last value after the handshake until it is overwritten by the next column-0 write.

Reset
REQ-022 While rst=0, the block SHALL hold: state IDLE, col 0, out_valid 0, out_data 0, busy 0, in_ready 1, input register 0.
REQ-023 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately and discard the partial result.
REQ-024 The first acceptance SHALL be possible on the first rising edge after rst is released.

Configuration
REQ-025 With INV_MIX_COLUMNS_FWD_MODE_EN defined, the block SHALL add an input port mode (1 bit), latched at acceptance: mode=1 selects forward MixColumns (02 03 01 01 circulant), mode=0 selects inverse; latency is identical for both.
REQ-026 Without INV_MIX_COLUMNS_FWD_MODE_EN, port mode SHALL be absent and the block SHALL be inverse-only.

Structure
REQ-027 The shared package aes_pkg SHALL hold: constant AES_POLY=8'h1B, functions gf_xtime and gf_mul (8-bit x 4-bit constant), the FSM state typedef, and the byte-index helper.
REQ-028 One sub-module, inv_mix_column_word (combinational, 32-bit column in/out, plus mode when the macro is defined), SHALL be instantiated once and time-shared across columns.

Verification
REQ-029 Column 0 in {8e,4d,a1,bc} (bytes 0,4,8,12), other columns {01,01,01,01} -> column 0 out {db,13,53,45}, others {01,01,01,01}, out_valid 4 cycles after acceptance.
REQ-030 All columns {d5,d5,d7,d6} -> all {d4,d4,d4,d5}; all columns {c6,c6,c6,c6} -> unchanged.
REQ-031 out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, out_valid=1; release with in_valid=1 -> both handshakes on one edge, busy=1 next cycle.
REQ-032 rst pulsed low during CALC at col=2 -> all outputs at reset values; a subsequent input yields the correct result with 4-cycle latency.
REQ-033 in_valid toggling during CALC with changing in_data -> result matches only the accepted word.
REQ-034 With INV_MIX_COLUMNS_FWD_MODE_EN: mode=1 with column {db,13,53,45} -> {8e,4d,a1,bc}; feeding that result back with mode=0 -> the original column.
